// File: rtl/pipe_reg_chain.sv
// DEPTH-stage, CHANNELS-lane back-pressured register pipeline with per-stage
// valid bits, bubble collapsing, flush and an occupancy counter.
module pipe_reg_chain #(
  parameter int DWIDTH   = 16,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 4,
  parameter int CNTW     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DWIDTH-1:0]   in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DWIDTH-1:0]   out_data,
  output logic [CNTW-1:0]              occupancy
);

  localparam int W = CHANNELS * DWIDTH;

  logic [DEPTH-1:0] v_q, v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH-1:0] cap;
  logic [W-1:0]     d_q   [DEPTH];
  logic [W-1:0]     d_d   [DEPTH];
  logic [W-1:0]     src_d [DEPTH];
  logic [CNTW-1:0]  occ_q, occ_d;
  logic             in_fire, out_fire;

  // Unrolled form of adv[i] = adv[i+1] | ~v[i]: a stage may advance unless it
  // and every stage downstream of it is valid while out_ready is low.
  for (genvar g = 0; g < DEPTH; g++) begin : g_adv
    assign adv[g] = out_ready | ~(&v_q[DEPTH-1:g]);
  end

  assign src_d[0] = in_data;
  for (genvar g = 1; g < DEPTH; g++) begin : g_src
    assign src_d[g] = d_q[g-1];
  end

  if (DEPTH == 1) begin : g_srcv_one
    assign src_v = in_valid;
  end else begin : g_srcv_many
    assign src_v = {v_q[DEPTH-2:0], in_valid};
  end

  assign in_ready  = adv[0] & ~flush;
  assign out_valid = v_q[DEPTH-1] & ~flush;
  assign out_data  = d_q[DEPTH-1];
  assign occupancy = occ_q;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Data only loads when a valid word arrives, so bubbles never toggle d_q.
  assign cap = adv & src_v & {DEPTH{~flush}};

  always_comb begin
    if (flush) begin
      v_d = '0;
    end else begin
      v_d = (adv & src_v) | (~adv & v_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    always_comb begin
      d_d[g] = d_q[g];
      if (cap[g]) begin
        d_d[g] = src_d[g];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        d_q[g] <= '0;
      end else begin
        d_q[g] <= d_d[g];
      end
    end
  end

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ_d = occ_q + CNTW'(1);
        2'b01:   occ_d = occ_q - CNTW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (DEPTH=4, CHANNELS=2, DWIDTH=16):
// directed phases plus random back-pressure, checked by a negedge monitor.
module tb_pipe_reg_chain;

  localparam int DW  = 16;
  localparam int CH  = 2;
  localparam int DP  = 4;
  localparam int CW  = $clog2(DP + 1);
  localparam int W   = CH * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] occupancy;

  pipe_reg_chain #(
    .DWIDTH   (DW),
    .CHANNELS (CH),
    .DEPTH    (DP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_word;
  logic [W-1:0] sb [$];
  logic         mon_en = 1'b0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data = '0;

  // Hand-computed {lane1 = -k, lane0 = k} words for k = 1..8.
  logic [W-1:0] tbl [8] = '{32'hFFFF_0001, 32'hFFFE_0002, 32'hFFFD_0003,
                            32'hFFFC_0004, 32'hFFFB_0005, 32'hFFFA_0006,
                            32'hFFF9_0007, 32'hFFF8_0008};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int k);
    logic [DW-1:0] lo, hi;
    lo       = DW'(k);
    hi       = -lo;
    in_data  = {hi, lo};
    exp_word = tbl[k-1];
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst || !mon_en) begin
      sb.delete();
      hold_prev <= 1'b0;
    end else begin
      chk("occ_vs_sb", 32'(occupancy), 32'(sb.size()));
      if (hold_prev && !flush) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_out", out_data, 32'hxxxx_xxxx);
        end else begin
          chk("out_data", out_data, sb.pop_front());
        end
      end
      if (in_valid && in_ready) sb.push_back(exp_word);
      if (flush) sb.delete();
      hold_prev <= out_valid & ~out_ready & ~flush;
      prev_data <= out_data;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int idx;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; exp_word = '0;

    // Reset with random inputs
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom); out_ready = 1'($urandom);
      flush = 1'($urandom); in_data = $urandom;
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Streaming: latency DEPTH, then back-to-back outputs
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      drive_word(i + 1);
      @(negedge clk);
      chk("stream_in_ready", 32'(in_ready), 32'd1);
      chk("stream_out_valid", 32'(out_valid), 32'(i >= 4));
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_tail_valid", 32'(out_valid), 32'd1);
      tick();
    end
    @(negedge clk);
    chk("stream_empty", 32'(out_valid), 32'd0);
    tick();

    // Fill / stall: only DEPTH words accepted
    out_ready = 1'b0;
    idx = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      drive_word(idx);
      @(negedge clk);
      if (in_ready) idx++;
      tick();
    end
    chk("fill_accepted", 32'(idx - 1), 32'd4);
    @(negedge clk);
    chk("fill_occupancy", 32'(occupancy), 32'd4);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_head", out_data, tbl[0]);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (idx <= 6) begin
        in_valid = 1'b1;
        drive_word(idx);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (i == 0) chk("full_passthru_ready", 32'(in_ready), 32'd1);
      if (in_valid && in_ready) idx++;
      if (idx > 6 && occupancy == 0) break;
      tick();
    end
    chk("drain_all_sent", 32'(idx), 32'd7);
    chk("drain_occ", 32'(occupancy), 32'd0);
    tick();

    // Bubble collapse
    out_ready = 1'b0;
    in_valid = 1'b1; drive_word(1); tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; drive_word(2); tick();
    in_valid = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("bubble_occ", 32'(occupancy), 32'd2);
    chk("bubble_head", out_data, tbl[0]);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bubble_out0", 32'(out_valid), 32'd1);
    tick();
    @(negedge clk);
    chk("bubble_out1", 32'(out_valid), 32'd1);
    chk("bubble_data1", out_data, tbl[1]);
    tick();
    @(negedge clk);
    chk("bubble_out2", 32'(out_valid), 32'd0);
    tick();

    // Flush with 3 words held
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; drive_word(i + 1); tick();
    end
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; drive_word(4);
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("post_flush_occ", 32'(occupancy), 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_flush_quiet", 32'(out_valid), 32'd0);
      tick();
    end

    // Random back-pressure
    for (int i = 0; i < 10000; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      exp_word  = in_data;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (occupancy == 0) break;
      tick();
    end
    chk("rand_drain_occ", 32'(occupancy), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
